// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: shared encodings for the multicycle controller.
package mc_controller_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
    } state_t;
    localparam logic [1:0] OP_DP = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;
    localparam logic [1:0] IMM_8 = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;
endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: instruction fields, ALU flags and datapath controls.
interface mc_controller_if;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] alu_control;
    modport slave (
        input  cond, op, funct, rd, alu_flags,
        output pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
               alu_src_b, result_src, imm_src, reg_src, alu_control
    );
    modport master (
        output cond, op, funct, rd, alu_flags,
        input  pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
               alu_src_b, result_src, imm_src, reg_src, alu_control
    );
endinterface

// File: rtl/mc_controller_cond_logic.sv
// mc_controller_cond_logic: flags register, condition evaluation and per-instruction condition latch.
module mc_controller_cond_logic
    import mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       latch_cond,
    output logic       cond_ex_q
);
    logic [3:0] flags_q, flags_d;
    logic       cond_ex, cond_ex_d;
    logic       n, z, c, v;
    assign {n, z, c, v} = flags_q;
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = n == v;
            COND_LT: cond_ex = n != v;
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
    // Flag writes are gated by the latched condition, never the live one.
    always_comb begin
        flags_d = {flag_w[1] & cond_ex_q ? alu_flags[3:2] : flags_q[3:2],
                   flag_w[0] & cond_ex_q ? alu_flags[1:0] : flags_q[1:0]};
        cond_ex_d = latch_cond ? cond_ex : cond_ex_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle Moore FSM, ALU/immediate decoders and gated write enables.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.slave bus
);
    state_t     state_q, state_d;
    logic       next_pc, branch, reg_w, mem_w, alu_op, ir_w;
    logic       adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, alu_control, flag_w;
    logic       no_write, pcs, cond_ex_q;
    logic [3:0] cmd;
    assign cmd = bus.funct[4:1];
    always_comb begin
        state_d = state_q;
        next_pc = 1'b0;
        branch = 1'b0;
        reg_w = 1'b0;
        mem_w = 1'b0;
        alu_op = 1'b0;
        ir_w = 1'b0;
        adr_src = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        result_src = 2'b00;
        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
                ir_w = 1'b1;
                next_pc = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                state_d = bus.op == OP_MEM ? S_MEMADR :
                          bus.op == OP_BR  ? S_BRANCH :
                          bus.op == OP_DP  ? (bus.funct[5] ? S_EXECUTEI : S_EXECUTER) : S_FETCH;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR: begin
                state_d = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                state_d = S_MEMWB;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
                result_src = 2'b01;
                reg_w = 1'b1;
            end
            S_MEMWRITE: begin
                state_d = S_FETCH;
                adr_src = 1'b1;
                mem_w = 1'b1;
            end
            S_EXECUTER: begin
                state_d = S_ALUWB;
                alu_op = 1'b1;
            end
            S_EXECUTEI: begin
                state_d = S_ALUWB;
                alu_op = 1'b1;
                alu_src_b = 2'b01;
            end
            S_ALUWB: begin
                state_d = S_FETCH;
                reg_w = 1'b1;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                alu_src_b = 2'b01;
                result_src = 2'b10;
                branch = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else state_q <= state_d;
    end
    // no_write depends on the DP command, not alu_op, so it still holds in ALUWB.
    always_comb begin
        alu_control = !alu_op ? ALU_ADD :
                      cmd == CMD_ADD ? ALU_ADD :
                      (cmd == CMD_SUB || cmd == CMD_CMP) ? ALU_SUB :
                      cmd == CMD_AND ? ALU_AND :
                      cmd == CMD_ORR ? ALU_ORR : ALU_ADD;
        no_write = bus.op == OP_DP && !(cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR});
        flag_w = {alu_op & bus.funct[0],
                  alu_op & bus.funct[0] & (cmd inside {CMD_ADD, CMD_SUB, CMD_CMP})};
    end
    mc_controller_cond_logic u_cond (
        .clk(clk),
        .reset(reset),
        .cond(bus.cond),
        .alu_flags(bus.alu_flags),
        .flag_w(flag_w),
        .latch_cond(state_q == S_DECODE),
        .cond_ex_q(cond_ex_q)
    );
    assign pcs = (bus.rd == 4'd15 & reg_w) | branch;
    assign bus.pc_write = ~reset & (next_pc | (pcs & cond_ex_q));
    assign bus.ir_write = ~reset & ir_w;
    assign bus.reg_write = ~reset & reg_w & cond_ex_q & ~no_write;
    assign bus.mem_write = ~reset & mem_w & cond_ex_q;
    assign bus.adr_src = adr_src;
    assign bus.alu_src_a = alu_src_a;
    assign bus.alu_src_b = alu_src_b;
    assign bus.result_src = result_src;
    assign bus.imm_src = bus.op;
    assign bus.reg_src = {bus.op == OP_MEM, bus.op == OP_BR};
    assign bus.alu_control = alu_control;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed instruction sequences for the multicycle controller.
module tb_mc_controller;
    import mc_controller_pkg::*;
    logic clk = 1'b0;
    logic reset;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    mc_controller_if bus();
    mc_controller dut (.clk(clk), .reset(reset), .bus(bus.slave));

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] fl);
        bus.cond = c;
        bus.op = o;
        bus.funct = f;
        bus.rd = r;
        bus.alu_flags = fl;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_instr(COND_AL, OP_DP, 6'b000000, 4'd0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_we cycle %0d: got %b want 0000", i,
                         {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write});
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== S_FETCH || bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: state=%0d ir=%b pc=%b want state=%0d ir=1 pc=1",
                     dut.state_q, bus.ir_write, bus.pc_write, S_FETCH);
        end
        checks++;
        if (dut.u_cond.flags_q !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", dut.u_cond.flags_q);
        end
    endtask

    task automatic test_adds;
        state_t     st[4] = '{S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB};
        logic [3:0] we[4] = '{4'b1100, 4'b0000, 4'b0000, 4'b0010};
        set_instr(COND_AL, OP_DP, 6'b101001, 4'd1, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (dut.state_q !== st[i] || {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write} !== we[i]) begin
                errors++;
                $display("FAIL adds cycle %0d: state=%0d we=%b want state=%0d we=%b", i, dut.state_q,
                         {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}, st[i], we[i]);
            end
            if (i == 2) begin
                checks++;
                if (bus.imm_src !== IMM_8 || bus.alu_control !== ALU_ADD) begin
                    errors++;
                    $display("FAIL adds_decode: imm_src=%b alu_control=%b want 00 00", bus.imm_src, bus.alu_control);
                end
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (dut.state_q !== S_FETCH || dut.u_cond.flags_q !== 4'b0100) begin
            errors++;
            $display("FAIL adds_end: state=%0d flags=%b want state=%0d flags=0100", dut.state_q, dut.u_cond.flags_q, S_FETCH);
        end
    endtask

    task automatic test_ldr_str;
        state_t     st_l[5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
        logic [3:0] we_l[5] = '{4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
        state_t     st_s[4] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE};
        logic [3:0] we_s[4] = '{4'b1100, 4'b0000, 4'b0000, 4'b0001};
        set_instr(COND_AL, OP_MEM, 6'b011001, 4'd3, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (dut.state_q !== st_l[i] || {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write} !== we_l[i]) begin
                errors++;
                $display("FAIL ldr cycle %0d: state=%0d we=%b want state=%0d we=%b", i, dut.state_q,
                         {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}, st_l[i], we_l[i]);
            end
            if (i == 3) begin
                checks++;
                if (bus.adr_src !== 1'b1 || bus.imm_src !== IMM_12) begin
                    errors++;
                    $display("FAIL ldr_memread: adr_src=%b imm_src=%b want 1 01", bus.adr_src, bus.imm_src);
                end
            end
            @(negedge clk);
        end
        set_instr(COND_AL, OP_MEM, 6'b011000, 4'd3, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (dut.state_q !== st_s[i] || {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write} !== we_s[i]) begin
                errors++;
                $display("FAIL str cycle %0d: state=%0d we=%b want state=%0d we=%b", i, dut.state_q,
                         {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}, st_s[i], we_s[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch(input logic taken);
        state_t st[3] = '{S_FETCH, S_DECODE, S_BRANCH};
        set_instr(COND_EQ, OP_BR, 6'b100000, 4'd0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (dut.state_q !== st[i] || bus.pc_write !== (i == 0 || (i == 2 && taken))) begin
                errors++;
                $display("FAIL beq taken=%b cycle %0d: state=%0d pc_write=%b want state=%0d pc_write=%b", taken, i,
                         dut.state_q, bus.pc_write, st[i], (i == 0 || (i == 2 && taken)));
            end
            if (i == 2) begin
                checks++;
                if (bus.imm_src !== IMM_24 || bus.reg_write !== 1'b0) begin
                    errors++;
                    $display("FAIL beq_decode: imm_src=%b reg_write=%b want 10 0", bus.imm_src, bus.reg_write);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_cmp_cond;
        logic [3:0] cnd[4] = '{COND_AL, COND_EQ, COND_NV, COND_EQ};
        logic [5:0] fn[4] = '{6'b010101, 6'b001000, 6'b001001, 6'b001001};
        logic [3:0] af[4] = '{4'b0100, 4'b1111, 4'b1001, 4'b0000};
        logic       rw[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] fq[4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
        for (int k = 0; k < 4; k++) begin
            set_instr(cnd[k], OP_DP, fn[k], 4'd2, af[k]);
            for (int i = 0; i < 4; i++) begin
                #1;
                if (i == 2 && k == 0) begin
                    checks++;
                    if (bus.alu_control !== ALU_SUB) begin
                        errors++;
                        $display("FAIL cmp_alu: alu_control=%b want 01", bus.alu_control);
                    end
                end
                if (i == 3) begin
                    checks++;
                    if (dut.state_q !== S_ALUWB || {bus.pc_write, bus.reg_write, bus.mem_write} !== {1'b0, rw[k], 1'b0}) begin
                        errors++;
                        $display("FAIL cond_seq %0d aluwb: state=%0d pc=%b reg=%b mem=%b want state=%0d reg=%b", k,
                                 dut.state_q, bus.pc_write, bus.reg_write, bus.mem_write, S_ALUWB, rw[k]);
                    end
                end
                @(negedge clk);
            end
            #1;
            checks++;
            if (dut.u_cond.flags_q !== fq[k]) begin
                errors++;
                $display("FAIL cond_seq %0d flags: got %b want %b", k, dut.u_cond.flags_q, fq[k]);
            end
        end
    endtask

    task automatic test_undef;
        set_instr(COND_AL, OP_UNDEF, 6'b111111, 4'd15, 4'b1111);
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (dut.state_q !== S_DECODE || {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write} !== 4'b0000) begin
            errors++;
            $display("FAIL undef_decode: state=%0d we=%b want state=%0d we=0000", dut.state_q,
                     {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}, S_DECODE);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dut.state_q !== S_FETCH) begin
            errors++;
            $display("FAIL undef_return: state=%0d want %0d", dut.state_q, S_FETCH);
        end
    endtask

    task automatic test_alu_decode;
        logic [5:0] fn[4] = '{6'b001000, 6'b000000, 6'b011000, 6'b000010};
        logic [3:0] r[4] = '{4'd15, 4'd4, 4'd4, 4'd4};
        logic [1:0] ac[4] = '{ALU_ADD, ALU_AND, ALU_ORR, ALU_ADD};
        logic [1:0] wb[4] = '{2'b11, 2'b01, 2'b01, 2'b00};
        for (int k = 0; k < 4; k++) begin
            set_instr(COND_AL, OP_DP, fn[k], r[k], 4'b0000);
            for (int i = 0; i < 4; i++) begin
                #1;
                if (i == 2) begin
                    checks++;
                    if (bus.alu_control !== ac[k]) begin
                        errors++;
                        $display("FAIL alu_decode %0d: alu_control=%b want %b", k, bus.alu_control, ac[k]);
                    end
                end
                if (i == 3) begin
                    checks++;
                    if ({bus.pc_write, bus.reg_write} !== wb[k]) begin
                        errors++;
                        $display("FAIL alu_wb %0d: pc/reg=%b want %b", k, {bus.pc_write, bus.reg_write}, wb[k]);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid;
        set_instr(COND_AL, OP_MEM, 6'b011000, 4'd3, 4'b0000);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (dut.state_q !== S_MEMWRITE || bus.mem_write !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: state=%0d mem_write=%b want state=%0d mem_write=1", dut.state_q, bus.mem_write, S_MEMWRITE);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_write !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_memwrite: got %b want 0", bus.mem_write);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== S_FETCH || bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1 || bus.mem_write !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: state=%0d ir=%b pc=%b mem=%b want state=%0d ir=1 pc=1 mem=0",
                     dut.state_q, bus.ir_write, bus.pc_write, bus.mem_write, S_FETCH);
        end
    endtask

    initial begin
        test_reset;
        test_adds;
        test_ldr_str;
        test_branch(1'b1);
        test_cmp_cond;
        test_branch(1'b0);
        test_undef;
        test_alu_decode;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cond  in  4  instr[31:28], the condition field.
REQ-005 op  in  2  instr[27:26]: 00 = data-processing (DP), 01 = memory, 10 = branch, 11 = undefined.
REQ-006 funct  in  6  instr[25:20]: [5] = I, [4:1] = cmd, [0] = S or L.
REQ-007 rd  in  4  instr[15:12].
REQ-008 alu_flags  in  4  {N,Z,C,V} from the ALU this cycle.
REQ-009 pc_write, ir_write, reg_write, mem_write  out  1 each  gated write enables.
REQ-010 adr_src  out  1  memory address select: 0 = PC, 1 = ALU result.
REQ-011 alu_src_a  out  1  ALU operand A: 0 = register, 1 = PC.
REQ-012 alu_src_b  out  2  ALU operand B: 00 = register, 01 = ext_imm, 10 = constant 4.
REQ-013 result_src  out  2  result mux: 00 = ALU out reg, 01 = data reg, 10 = ALU direct.
REQ-014 imm_src  out  2  drives the Extend unit: 00 = 8-bit, 01 = 12-bit, 10 = 24-bit branch.
REQ-015 reg_src  out  2  register read-address select.
REQ-016 alu_control  out  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.

Function
REQ-017 Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-018 Transitions (all on a clock edge):
- FETCH->DECODE.
- DECODE: op=01 -> MEMADR; op=00 and funct[5]=0 -> EXECUTER; op=00 and funct[5]=1 -> EXECUTEI; op=10 -> BRANCH; op=11 -> FETCH.
- MEMADR: funct[0]=1 -> MEMREAD, else MEMWRITE.
- MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH.
- EXECUTER/EXECUTEI->ALUWB->FETCH; BRANCH->FETCH.
REQ-019 State outputs (unlisted signals = 0):
- FETCH: ir_write=1, next_pc=1, alu_src_a=1, alu_src_b=10, result_src=10.
- DECODE: alu_src_a=1, alu_src_b=10, result_src=10.
- MEMADR: alu_src_b=01.
- MEMREAD: adr_src=1.
- MEMWB: result_src=01, reg_w=1.
- MEMWRITE: adr_src=1, mem_w=1.
- EXECUTER: alu_op=1, alu_src_b=00.
- EXECUTEI: alu_op=1, alu_src_b=01.
- ALUWB: reg_w=1.
- BRANCH: alu_src_b=01, result_src=10, branch=1.
REQ-020 imm_src shall equal op combinationally; reg_src[0] = (op==10); reg_src[1] = (op==01).
REQ-021 ALU decode when alu_op=1, by funct[4:1]:
- 0100 ADD -> 00; 0010 SUB -> 01; 0000 AND -> 10; 1100 ORR -> 11.
- 1010 CMP -> 01 with no_write=1.
- Any other cmd -> 00 with no_write=1.
- When alu_op=0, alu_control = 00.
REQ-022 flag_w[1] (N,Z) = alu_op & funct[0]; flag_w[0] (C,V) = alu_op & funct[0] & cmd in {ADD, SUB, CMP}.
REQ-023 cond_ex is evaluated from the flags register for all 15 ARM codes (EQ..LE, 1110 = AL). Code 1111 yields 0.
REQ-024 cond_ex is latched into cond_ex_q at the end of DECODE. All gating in later states uses cond_ex_q, so a flag update inside the same instruction never alters its own condition.
REQ-025 The flags register updates at the end of EXECUTER/EXECUTEI, per half, when flag_w & cond_ex_q; it is otherwise held.
REQ-026 Gated outputs:
- pcs = (rd==15 & reg_w) | branch.
- pc_write = next_pc | (pcs & cond_ex_q).
- reg_write = reg_w & cond_ex_q & ~no_write.
- mem_write = mem_w & cond_ex_q.
REQ-027 With op=11, the FSM returns to FETCH after DECODE and no write enable is asserted.

Reset
REQ-028 While reset=1, pc_write, ir_write, reg_write and mem_write shall be 0. On the edge where reset=1: state <= FETCH, flags <= 0000, cond_ex_q <= 0.
REQ-029 A reset asserted in any state, including mid-instruction, aborts that instruction. The first cycle after release is FETCH with ir_write=1 and pc_write=1.

Structure
REQ-030 Shared package holds: the state enum, alu_control codes, imm_src codes, cond code constants and the op codes.
REQ-031 One sub-module, cond_logic: flags register, cond_ex evaluation and cond_ex_q latch. The FSM and decoders stay in mc_controller.

Verification
REQ-032 Reset held 3 cycles, then released -> write enables 0 during reset; cycle 1 after release is FETCH with ir_write=1, pc_write=1.
REQ-033 ADDS R1,R2,#5 (cond=1110, op=00, funct=101001, rd=1), alu_flags=0100 -> 4-cycle sequence FETCH, DECODE, EXECUTEI, ALUWB; imm_src=00; alu_control=00; reg_write=1 in ALUWB; flags=0100 afterwards.
REQ-034 LDR (op=01, funct=011001) -> 5-cycle sequence ending in MEMWB; imm_src=01; adr_src=1 in MEMREAD; reg_write=1 in MEMWB. STR (funct[0]=0) -> MEMWRITE with mem_write=1, reg_write never 1.
REQ-035 With Z=0, BEQ (cond=0000, op=10) -> imm_src=10; BRANCH state reached; pc_write=0 in BRANCH. With Z=1 -> pc_write=1 in BRANCH.
REQ-036 CMP (funct[4:1]=1010, S=1) followed by ADDEQ -> CMP gives reg_write=0 and updates flags; ADDEQ uses the new Z; cond=1111 yields no writes.
REQ-037 Reset asserted in MEMWRITE -> mem_write=0 that cycle; FETCH on the next cycle after release.
